matrix_result_serializer: RTL and testbench

MATRIX_RESULT_SERIALIZER -- requirements
Module: matrix_result_serializer

---
 rtl/matrix_result_serializer.sv | 108 ++++++++++
 tb/tb_matrix_result_serializer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_serializer.sv
// matrix_result_serializer: captures a 3x3 result matrix on a done rising edge and streams it byte-wise over valid/ready.
// Optional feature: define RESULT_CHECKSUM_EN to append an XOR checksum byte (CSUM state).
module matrix_result_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] c0,
    input  logic [7:0] c1,
    input  logic [7:0] c2,
    input  logic [7:0] c3,
    input  logic [7:0] c4,
    input  logic [7:0] c5,
    input  logic [7:0] c6,
    input  logic [7:0] c7,
    input  logic [7:0] c8,
    input  logic       done,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);
`ifdef RESULT_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SEND, CSUM, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;
`endif

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       done_d_q, done_d_d;
    logic       overrun_q, overrun_d;
    logic [7:0] cap_q [9];
    logic [7:0] cap_d [9];
    logic       start, fire;

`ifdef RESULT_CHECKSUM_EN
    logic [7:0] csum;
    // XOR of the captured matrix, offered as the trailing byte
    always_comb begin
        csum = 8'd0;
        for (int i = 0; i < 9; i++) csum = csum ^ cap_q[i];
    end
`endif

    // Outputs decoded from the current state; the byte comes from the captured copy
    always_comb begin
        tx_valid   = state_q == SEND;
        tx_data    = state_q == SEND ? cap_q[idx_q] : 8'd0;
`ifdef RESULT_CHECKSUM_EN
        if (state_q == CSUM) begin
            tx_valid = 1'b1;
            tx_data  = csum;
        end
`endif
        busy       = state_q != IDLE;
        frame_done = state_q == FIN;
        overrun    = overrun_q;
    end

    // Next-state logic: edge-detect done, capture on start, advance on each handshake
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cap_d     = cap_q;
        done_d_d  = done;
        start     = done & ~done_d_q;
        fire      = tx_valid & tx_ready;
        overrun_d = overrun_q | (start & (state_q != IDLE));
        case (state_q)
            IDLE: if (start) begin
                state_d = SEND;
                idx_d   = 4'd0;
                cap_d   = '{c0, c1, c2, c3, c4, c5, c6, c7, c8};
            end
            SEND: if (fire) begin
                idx_d = idx_q == 4'd8 ? 4'd0 : idx_q + 4'd1;
`ifdef RESULT_CHECKSUM_EN
                if (idx_q == 4'd8) state_d = CSUM;
`else
                if (idx_q == 4'd8) state_d = FIN;
`endif
            end
`ifdef RESULT_CHECKSUM_EN
            CSUM: if (fire) state_d = FIN;
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset that aborts any frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            done_d_q  <= 1'b0;
            overrun_q <= 1'b0;
            cap_q     <= '{default: 8'd0};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            done_d_q  <= done_d_d;
            overrun_q <= overrun_d;
            cap_q     <= cap_d;
        end
    end
endmodule

// File: tb/tb_matrix_result_serializer.sv
// tb_matrix_result_serializer: directed + randomized checks of the serializer against a queue-based frame model.
module tb_matrix_result_serializer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] m [9];
    logic       done;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       frame_done;
    logic       overrun;
    int         n_tests = 0;
    int         n_fail = 0;

    matrix_result_serializer dut (
        .clk(clk), .rst(rst),
        .c0(m[0]), .c1(m[1]), .c2(m[2]), .c3(m[3]), .c4(m[4]),
        .c5(m[5]), .c6(m[6]), .c7(m[7]), .c8(m[8]),
        .done(done), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A*B with A=[1..9], B=[9..1], truncated to bytes as the upstream stage produces
    task automatic load_product();
        int a [9];
        int b [9];
        for (int i = 0; i < 9; i++) begin
            a[i] = i + 1;
            b[i] = 9 - i;
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                m[r*3+c] = 8'(a[r*3]*b[c] + a[r*3+1]*b[3+c] + a[r*3+2]*b[6+c]);
    endtask

    task automatic load_random();
        for (int i = 0; i < 9; i++) m[i] = 8'($urandom);
    endtask

    task automatic run_frame(input string tag, input int pct, input int pulse_at, input int stall_at,
                             input int abort_at, input bit hold_done, input bit fin_pulse);
        logic [7:0] exp [$];
        logic [7:0] x;
        int sent, cyc, stall, n;
        sent = 0; cyc = 0; stall = 0; x = 8'd0;
        for (int i = 0; i < 9; i++) begin
            exp.push_back(m[i]);
            x ^= m[i];
        end
`ifdef RESULT_CHECKSUM_EN
        exp.push_back(x);
`endif
        n = exp.size();
        done = 1'b1;
        tick();
        if (!hold_done) done = 1'b0;
        chk({tag, " busy_start"}, busy, 1);
        while (exp.size() > 0 && cyc < 200) begin
            if (sent == abort_at) begin
                rst = 1'b0;
                #1;
                chk({tag, " rst_valid"}, tx_valid, 0);
                chk({tag, " rst_data"}, tx_data, 0);
                chk({tag, " rst_busy"}, busy, 0);
                chk({tag, " rst_fdone"}, frame_done, 0);
                chk({tag, " rst_ovr"}, overrun, 0);
                tick();
                rst = 1'b1;
                tx_ready = 1'b1;
                repeat (5) begin
                    tick();
                    chk({tag, " post_rst_valid"}, tx_valid, 0);
                    chk({tag, " post_rst_busy"}, busy, 0);
                end
                return;
            end
            chk({tag, " valid"}, tx_valid, 1);
            chk({tag, " data"}, tx_data, exp[0]);
            if (!hold_done) done = (cyc == pulse_at);
            load_random();
            if (sent == stall_at && stall < 3) begin
                tx_ready = 1'b0;
                stall++;
            end else tx_ready = $urandom_range(99) < pct;
            if (tx_ready) begin
                void'(exp.pop_front());
                sent++;
            end
            tick();
            cyc++;
        end
        chk({tag, " bytes_left"}, exp.size(), 0);
        if (pct == 100 && stall_at < 0) chk({tag, " cycles"}, cyc, n);
        if (pct == 100 && stall_at >= 0) chk({tag, " cycles_stall"}, cyc, n + 3);
        chk({tag, " fin_fdone"}, frame_done, 1);
        chk({tag, " fin_valid"}, tx_valid, 0);
        chk({tag, " fin_busy"}, busy, 1);
        tx_ready = 1'b0;
        if (fin_pulse) done = 1'b1;
        tick();
        chk({tag, " idle_fdone"}, frame_done, 0);
        chk({tag, " idle_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b0;
        done = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) m[i] = 8'd0;
        repeat (2) tick();
        chk("reset tx_valid", tx_valid, 0);
        chk("reset tx_data", tx_data, 0);
        chk("reset busy", busy, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset overrun", overrun, 0);
        rst = 1'b1;
        tick();
        chk("idle busy", busy, 0);

        load_product();
        run_frame("product", 100, -1, -1, -1, 1'b0, 1'b0);
        chk("product overrun", overrun, 0);

        load_product();
        run_frame("stall", 100, -1, 4, -1, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            load_random();
            run_frame("random", 30 + 10 * k, -1, -1, -1, 1'b0, 1'b0);
            repeat ($urandom_range(3)) tick();
        end
        chk("random overrun", overrun, 0);

        load_product();
        run_frame("pulse", 100, 2, -1, -1, 1'b0, 1'b0);
        chk("pulse overrun", overrun, 1);
        load_random();
        run_frame("sticky", 60, -1, -1, -1, 1'b0, 1'b0);
        chk("sticky overrun", overrun, 1);

        load_product();
        run_frame("abort", 100, -1, -1, 5, 1'b0, 1'b0);
        chk("abort overrun", overrun, 0);

        load_random();
        run_frame("held", 100, -1, -1, -1, 1'b1, 1'b0);
        repeat (41) begin
            tick();
            chk("held idle busy", busy, 0);
        end
        chk("held overrun", overrun, 0);
        done = 1'b0;
        tick();

        load_random();
        run_frame("finpulse", 100, -1, -1, -1, 1'b0, 1'b1);
        tick();
        chk("finpulse busy", busy, 0);
        chk("finpulse valid", tx_valid, 0);
        chk("finpulse overrun", overrun, 1);
        done = 1'b0;

        rst = 1'b0;
        done = 1'b1;
        tick();
        rst = 1'b1;
        load_random();
        run_frame("rel_start", 100, -1, -1, -1, 1'b0, 1'b0);
        chk("rel_start overrun", overrun, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
